// File: rtl/asmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : asmd_pkg
//  Purpose  : Shared types and helpers for the ASMD Booth multiplier
//  Revision : 1.0  initial release
// ============================================================================
package asmd_pkg;

  // Controller states of the multiplier
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operation selected by one radix-2 Booth step
  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // Number of bits needed to encode values 0..value-1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asmd_booth_step.sv
`default_nettype none
// ============================================================================
//  Module   : asmd_booth_step
//  Purpose  : One combinational radix-2 Booth step: add/sub of M into A,
//             then arithmetic right shift of {A, Q, Q_-1}
//  Revision : 1.0  initial release
// ============================================================================
module asmd_booth_step
  import asmd_pkg::*;
#(
  parameter int word_length = 8
) (
  input  logic [word_length+1:0] i_a,
  input  logic [word_length:0]   i_q,
  input  logic                   i_qm1,
  input  logic [word_length:0]   i_m,
  output logic [word_length+1:0] o_a,
  output logic [word_length:0]   o_q,
  output logic                   o_qm1
);

  booth_op_e                w_op;
  logic [word_length+1:0]   w_m_ext;
  logic [word_length+1:0]   w_sum;

  // M is already sign/zero extended by one bit; widen once more to A's width
  assign w_m_ext = {i_m[word_length], i_m};

  // Decode the Booth pair and form the new accumulator before the shift
  always_comb begin
    w_op  = BOOTH_NOP;
    w_sum = i_a;
    case ({i_q[0], i_qm1})
      2'b01:   w_op = BOOTH_ADD;
      2'b10:   w_op = BOOTH_SUB;
      default: w_op = BOOTH_NOP;
    endcase
    case (w_op)
      BOOTH_ADD: w_sum = i_a + w_m_ext;
      BOOTH_SUB: w_sum = i_a - w_m_ext;
      default:   w_sum = i_a;
    endcase
  end

  // Arithmetic shift right of {A, Q, Q_-1} by one position
  assign o_a   = {w_sum[word_length+1], w_sum[word_length+1:1]};
  assign o_q   = {w_sum[0], i_q[word_length:1]};
  assign o_qm1 = i_q[0];

endmodule
`default_nettype wire

// File: rtl/asmd_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : asmd_booth_multiplier
//  Purpose  : Sequential radix-2 Booth multiplier, signed or unsigned per
//             operation, start/ready/done handshake, one step per clock
//  Revision : 1.0  initial release
// ============================================================================
module asmd_booth_multiplier
  import asmd_pkg::*;
#(
  parameter int word_length = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [word_length-1:0]     word0,
  input  logic [word_length-1:0]     word1,
  output logic                       ready,
  output logic                       done,
  output logic [2*word_length-1:0]   product
);

  localparam int                CNT_W    = clog2(word_length + 2);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(word_length + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  state_e                     state_q, state_d;
  logic [word_length+1:0]     a_q, a_d;
  logic [word_length:0]       q_q, q_d;
  logic                       qm1_q, qm1_d;
  logic [word_length:0]       m_q, m_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       ready_q, ready_d;
  logic                       done_q, done_d;
  logic [2*word_length-1:0]   product_q, product_d;

  logic [word_length+1:0]     step_a;
  logic [word_length:0]       step_q;
  logic                       step_qm1;
  logic                       zero_op;

  asmd_booth_step #(
    .word_length (word_length)
  ) u_step (
    .i_a   (a_q),
    .i_q   (q_q),
    .i_qm1 (qm1_q),
    .i_m   (m_q),
    .o_a   (step_a),
    .o_q   (step_q),
    .o_qm1 (step_qm1)
  );

  assign zero_op = (word0 == '0) || (word1 == '0);

  // Next-state, datapath and registered-output logic of the controller
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          ready_d = 1'b0;
          state_d = S_RUN;
          a_d     = '0;
          qm1_d   = 1'b0;
          if (zero_op) begin
            // A zero operand short-circuits to a single all-zero step, so the
            // zero result retires one edge after start
            q_d     = '0;
            m_d     = '0;
            count_d = CNT_LAST;
          end else begin
            q_d     = {signed_mode & word1[word_length-1], word1};
            m_d     = {signed_mode & word0[word_length-1], word0};
            count_d = CNT_LOAD;
          end
        end
      end
      S_RUN: begin
        ready_d = 1'b0;
        a_d     = step_a;
        q_d     = step_q;
        qm1_d   = step_qm1;
        count_d = count_q - CNT_LAST;
        if (count_q == CNT_LAST) begin
          product_d = {step_a[word_length-2:0], step_q};
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_asmd_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asmd_booth_multiplier
//  Purpose  : Directed, table-driven bench for asmd_booth_multiplier (w=8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_asmd_booth_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [7:0]  word0;
  logic [7:0]  word1;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int n_pass;
  int n_total;

  typedef struct {
    logic        sm;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  asmd_booth_multiplier #(
    .word_length (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .word0       (word0),
    .word1       (word1),
    .ready       (ready),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Counts edges (sampled #1 after each) until done is seen, bounded
  task automatic wait_done(input int first, output int edges);
    int n;
    n = first;
    while (!done && n < first + 30) begin
      @(posedge clk); #1;
      n++;
    end
    edges = done ? n : -1;
  endtask

  // Full operation: start sampled on edge 0, checks latency, product, handshake
  task automatic do_op(input string name, input logic sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp_p, input int exp_lat);
    int   lat;
    logic [15:0] p_at_done;
    @(negedge clk);
    signed_mode = sm; word0 = a; word1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, lat);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " product"}, product, exp_p);
    chk({name, " ready_during_done"}, ready, 1'b0);
    p_at_done = product;
    @(posedge clk); #1;
    chk({name, " ready_after"}, ready, 1'b1);
    chk({name, " done_pulse"}, done, 1'b0);
    chk({name, " product_hold"}, product, exp_p);
  endtask

  initial begin
    int lat;
    n_pass = 0; n_total = 0;
    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; word0 = '0; word1 = '0;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 9};
    vecs[1] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 9};
    vecs[2] = '{1'b0, 8'hFD, 8'h05, 16'h04F1, 9};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000, 9};
    vecs[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 9};
    vecs[5] = '{1'b0, 8'h00, 8'h5A, 16'h0000, 1};
    vecs[6] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 9};
    vecs[7] = '{1'b0, 8'h5A, 8'h00, 16'h0000, 1};
    vecs[8] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 9};
    vecs[9] = '{1'b0, 8'h80, 8'h80, 16'h4000, 9};

    // Reset state
    #12;
    chk("reset ready", ready, 1'b1);
    chk("reset done", done, 1'b0);
    chk("reset product", product, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle ready", ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].sm, vecs[i].w0, vecs[i].w1,
            vecs[i].exp_p, vecs[i].exp_lat);
    end

    // Busy-start rejection: second start on edge 4 must be ignored
    @(negedge clk);
    signed_mode = 1'b0; word0 = 8'h12; word1 = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    word0 = 8'h02; word1 = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy ready_low", ready, 1'b0);
    wait_done(4, lat);
    chk("busy latency", lat, 9);
    chk("busy product", product, 16'h03A8);
    repeat (4) @(posedge clk);
    #1;
    chk("busy idle_hold", product, 16'h03A8);
    chk("busy idle_ready", ready, 1'b1);

    // Reset in the middle of a run
    @(negedge clk);
    word0 = 8'h0F; word1 = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun product_hold", product, 16'h03A8);
    chk("midrun ready_low", ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort ready", ready, 1'b1);
    chk("abort done", done, 1'b0);
    chk("abort product", product, 16'h0000);
    repeat (12) @(posedge clk);
    #1;
    chk("abort no_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_op("post_reset", 1'b0, 8'h03, 8'h04, 16'h000C, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
